keypad_emulator: RTL and testbench

- Electrical stand-in for the 4x4 matrix keypad, sitting on the far side of the keypad scanner.
- It watches the scanner's active-low row drive and pulls the matching active-low column line low while a virtual key is "pressed".
- It models contact bounce on press and on release.
- Used for loopback self-test on the board and as the stimulus model in scanner benches. Key code in, row/column wiring out.

---
 rtl/keypad_emulator.sv | 180 ++++++++++++++++++
 tb/tb_keypad_emulator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Matrix keypad stand-in: pulls the selected active-low column low while the
// selected row is driven low and the virtual contact is closed, with contact bounce.
module keypad_emulator #(
    parameter int HOLD_CYCLES  = 5000000,
    parameter int BOUNCE_STEP  = 20000,
    parameter int BOUNCE_COUNT = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] key_code,
    input  logic       press,
    output logic       busy,
    output logic       done,
    input  logic [3:0] linhaN,
    output logic [3:0] colunaN
);

    localparam int CNT_MAX = (HOLD_CYCLES > BOUNCE_STEP) ? HOLD_CYCLES : BOUNCE_STEP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = (BOUNCE_COUNT > 1) ? $clog2(BOUNCE_COUNT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(BOUNCE_STEP - 1);
    localparam logic [TW-1:0] TOG_LAST  = TW'((BOUNCE_COUNT > 0) ? BOUNCE_COUNT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tog_q, tog_d;
    logic            contact_q, contact_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [3:0]      coluna_q, coluna_d;

    // Returns {row, col} for a key code, matching the scanner's decode table.
    function automatic logic [3:0] key_map(input logic [3:0] code);
        logic [3:0] rc;
        case (code)
            4'h1:    rc = {2'd0, 2'd0};
            4'h2:    rc = {2'd0, 2'd1};
            4'h3:    rc = {2'd0, 2'd2};
            4'hA:    rc = {2'd0, 2'd3};
            4'h4:    rc = {2'd1, 2'd0};
            4'h5:    rc = {2'd1, 2'd1};
            4'h6:    rc = {2'd1, 2'd2};
            4'hB:    rc = {2'd1, 2'd3};
            4'h7:    rc = {2'd2, 2'd0};
            4'h8:    rc = {2'd2, 2'd1};
            4'h9:    rc = {2'd2, 2'd2};
            4'hC:    rc = {2'd2, 2'd3};
            4'hF:    rc = {2'd3, 2'd0};
            4'h0:    rc = {2'd3, 2'd1};
            4'hE:    rc = {2'd3, 2'd2};
            default: rc = {2'd3, 2'd3};
        endcase
        return rc;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        contact_d = contact_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        row_d     = row_q;
        col_d     = col_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    {row_d, col_d} = key_map(key_code);
                    busy_d    = 1'b1;
                    contact_d = 1'b1;
                    cnt_d     = '0;
                    tog_d     = '0;
                    state_d   = (BOUNCE_COUNT == 0) ? S_HOLD : S_BOUNCE_IN;
                end
            end

            // Both bounce phases begin closed and alternate every step; the exit
            // toggle lands on the phase's resting level (closed in, open out).
            S_BOUNCE_IN, S_BOUNCE_OUT: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (tog_q == TOG_LAST) begin
                        tog_d = '0;
                        if (state_q == S_BOUNCE_IN) begin
                            contact_d = 1'b1;
                            state_d   = S_HOLD;
                        end else begin
                            contact_d = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            state_d   = S_DONE;
                        end
                    end else begin
                        tog_d     = tog_q + TW'(1);
                        contact_d = ~contact_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (BOUNCE_COUNT == 0) begin
                        contact_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_BOUNCE_OUT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                contact_d = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = '0;
                tog_d     = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign coluna_d[gi] = ~(contact_q && !linhaN[row_q] && (col_q == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tog_q     <= '0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            coluna_q  <= 4'hF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            contact_q <= contact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            row_q     <= row_d;
            col_q     <= col_d;
            coluna_q  <= coluna_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign colunaN = coluna_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a bouncing instance and a bounce-free
// instance, with column expectations queued per cycle from a timeline model.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_code;
    logic [3:0] linhaN;
    logic       press_b, press_n;
    logic       busy_b, done_b, busy_n, done_n;
    logic [3:0] col_b, col_n;

    int total = 0;
    int bad   = 0;

    logic [3:0] kp [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                              '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC},
                              '{4'hF, 4'h0, 4'hE, 4'hD}};

    always #5 clk = ~clk;

    keypad_emulator #(.HOLD_CYCLES(10), .BOUNCE_STEP(4), .BOUNCE_COUNT(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .key_code(key_code), .press(press_b),
        .busy(busy_b), .done(done_b), .linhaN(linhaN), .colunaN(col_b)
    );

    keypad_emulator #(.HOLD_CYCLES(16), .BOUNCE_STEP(4), .BOUNCE_COUNT(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .key_code(key_code), .press(press_n),
        .busy(busy_n), .done(done_n), .linhaN(linhaN), .colunaN(col_n)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Contact state i cycles after acceptance: bounce-in, hold, bounce-out, open.
    function automatic bit contact_exp(input int i, input int bc, input int step, input int hold);
        int b = bc * step;
        if (i < b)            return ((i / step) % 2) == 0;
        if (i < b + hold)     return 1'b1;
        if (i < 2 * b + hold) return (((i - b - hold) / step) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic run_press(input bit sel, input logic [3:0] code, input int bc,
                             input int step, input int hold, input bit rotate,
                             input logic [3:0] lin_fix, input int lock_i,
                             input logic [3:0] lock_code, input string name);
        logic [3:0] exp_q[$];
        logic [3:0] lin;
        logic [3:0] obs_col;
        int r = 0, c = 0;
        int last = 2 * bc * step + hold;
        int dones = 0;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (kp[rr][cc] == code) begin r = rr; c = cc; end

        @(negedge clk);
        key_code = code;
        if (sel) press_n = 1'b1; else press_b = 1'b1;
        linhaN = lin_fix;
        exp_q.push_back(4'hF);
        for (int i = 0; i < last + 3; i++) begin
            @(negedge clk);
            if (sel) press_n = (i == lock_i); else press_b = (i == lock_i);
            if (i == lock_i) key_code = lock_code;
            obs_col = sel ? col_n : col_b;
            chk({name, "_col"}, obs_col, exp_q.pop_front());
            chk({name, "_busy"}, {3'b0, sel ? busy_n : busy_b}, {3'b0, i < last});
            chk({name, "_done"}, {3'b0, sel ? done_n : done_b}, {3'b0, i == last});
            if (sel ? done_n : done_b) dones++;
            lin = rotate ? ~(4'b0001 << (i % 4)) : lin_fix;
            linhaN = lin;
            exp_q.push_back((contact_exp(i, bc, step, hold) && !lin[r]) ? ~(4'b0001 << c) : 4'hF);
        end
        @(negedge clk);
        obs_col = sel ? col_n : col_b;
        chk({name, "_col_tail"}, obs_col, exp_q.pop_front());
        chk({name, "_done_count"}, 4'(dones), 4'd1);
        $display("press %s code=%h row=%0d col=%0d done_pulses=%0d", name, code, r, c, dones);
    endtask

    initial begin
        reset_n  = 1'b0;
        press_b  = 1'b0;
        press_n  = 1'b0;
        key_code = 4'h0;
        linhaN   = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_col_b", col_b, 4'hF);
        chk("rst_busy_b", {3'b0, busy_b}, 4'd0);
        chk("rst_done_b", {3'b0, done_b}, 4'd0);
        chk("rst_col_n", col_n, 4'hF);
        chk("rst_busy_n", {3'b0, busy_n}, 4'd0);
        chk("rst_done_n", {3'b0, done_n}, 4'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Bounce shape: code 5 with all rows driven low.
        run_press(1'b0, 4'h5, 4, 4, 10, 1'b0, 4'h0, -1, 4'h0, "bounce");

        // Full key map with a rotating single-zero row drive.
        for (int k = 0; k < 16; k++)
            run_press(1'b1, 4'(k), 0, 4, 16, 1'b1, 4'hF, -1, 4'h0, "map");

        // Second press during HOLD must be ignored.
        run_press(1'b1, 4'h1, 0, 4, 16, 1'b0, 4'h0, 5, 4'h9, "lockout");

        // Key row never driven: other rows low, row 2 high.
        run_press(1'b1, 4'h7, 0, 4, 16, 1'b0, 4'b0100, -1, 4'h0, "wrong_row");

        // Asynchronous reset in the middle of HOLD.
        @(negedge clk);
        key_code = 4'h1;
        linhaN   = 4'h0;
        press_b  = 1'b1;
        @(negedge clk);
        press_b = 1'b0;
        repeat (19) @(negedge clk);
        chk("midhold_col", col_b, 4'hE);
        chk("midhold_busy", {3'b0, busy_b}, 4'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_col", col_b, 4'hF);
        chk("async_rst_busy", {3'b0, busy_b}, 4'd0);
        chk("async_rst_done", {3'b0, done_b}, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {3'b0, busy_b}, 4'd0);
        key_code = 4'h2;
        press_b  = 1'b1;
        @(negedge clk);
        press_b = 1'b0;
        chk("post_rst_accept", {3'b0, busy_b}, 4'd1);
        @(negedge clk);
        chk("post_rst_col", col_b, 4'hD);
        $display("press reset_mid_hold code=1 then code=2 accepted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
